// File: rtl/ads8688_pkg.sv
// Shared constants, command decode helpers and FSM encoding for the ADS8688 SPI responder.
package ads8688_pkg;

  localparam int CMD_BITS_DEFAULT   = 16;
  localparam int DATA_BITS_DEFAULT  = 16;
  localparam int FRAME_BITS_DEFAULT = CMD_BITS_DEFAULT + DATA_BITS_DEFAULT;

  localparam logic [15:0] CMD_NO_OP      = 16'h0000;
  localparam logic [15:0] CMD_RST        = 16'h8500;
  localparam logic [2:0]  CMD_MAN_PREFIX = 3'b110;

  localparam int CH_LSB = 10;
  localparam int CH_MSB = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_e;

  // Manual-channel select: prefix, channel field, all-zero tail.
  function automatic logic is_man_ch(input logic [15:0] cmd);
    return (cmd[15:13] == CMD_MAN_PREFIX) && (cmd[CH_LSB-1:0] == '0);
  endfunction

  function automatic logic cmd_known(input logic [15:0] cmd);
    return (cmd == CMD_NO_OP) || (cmd == CMD_RST) || is_man_ch(cmd);
  endfunction

endpackage

// File: rtl/ads8688_spi_resp_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              level;

  assign level = sync_q[STAGES-1];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= level;
    end
  end

  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/ads8688_spi_resp.sv
// ADS8688-side SPI responder: shifts in a command, returns the pipelined conversion word,
// and applies channel-select commands when the frame completes.
module ads8688_spi_resp
  import ads8688_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_BITS    = CMD_BITS_DEFAULT,
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 sclk,
  input  logic                 csn,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic [2:0]           cur_ch,
  output logic                 conv_strobe,
  output logic                 cmd_valid,
  output logic [CMD_BITS-1:0]  cmd_word,
  output logic                 cmd_unsup,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall_unused, csn_rise, csn_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .arst   (arst),
    .d_i    (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
    .clk    (clk),
    .arst   (arst),
    .d_i    (csn),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  // mosi gets the same depth as sclk so the sampled bit lines up with the detected rise.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) mosi_sync_q <= '0;
    else      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e                state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [CMD_BITS-2:0]   cmd_sr_q;
  logic [CMD_BITS-1:0]   cmd_word_q;
  logic [DATA_BITS-1:0]  shift_out_q;
  logic [DATA_BITS-1:0]  data_hold_q;
  logic [2:0]            cur_ch_q;
  logic                  miso_q;
  logic                  cmd_valid_q, cmd_unsup_q, frame_err_q, conv_strobe_q;
  logic [CMD_BITS-1:0]   cmd_d;

  assign cmd_d = {cmd_sr_q, mosi_s};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      cmd_sr_q      <= '0;
      cmd_word_q    <= '0;
      shift_out_q   <= '0;
      data_hold_q   <= '0;
      cur_ch_q      <= '0;
      miso_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_unsup_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      conv_strobe_q <= 1'b0;
    end else begin
      cmd_valid_q   <= 1'b0;
      cmd_unsup_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      conv_strobe_q <= 1'b0;
      if (conv_strobe_q) data_hold_q <= sample_in;

      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (csn_fall) begin
            bit_cnt_q   <= '0;
            // A frame starting on the capture cycle must still see the fresh sample.
            shift_out_q <= conv_strobe_q ? sample_in : data_hold_q;
            state_q     <= ST_CMD;
          end
        end
        default: begin
          if (csn_rise) begin
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
            if (state_q == ST_DONE) begin
              conv_strobe_q <= 1'b1;
              if (cmd_word_q == CMD_RST)     cur_ch_q <= '0;
              else if (is_man_ch(cmd_word_q)) cur_ch_q <= cmd_word_q[CH_MSB:CH_LSB];
            end else begin
              frame_err_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            case (state_q)
              ST_CMD: begin
                cmd_sr_q  <= cmd_d[CMD_BITS-2:0];
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_CMD) begin
                  cmd_word_q  <= cmd_d;
                  cmd_valid_q <= 1'b1;
                  cmd_unsup_q <= ~cmd_known(cmd_d);
                  miso_q      <= shift_out_q[DATA_BITS-1];
                  state_q     <= ST_DATA;
                end
              end
              ST_DATA: begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_FRAME) begin
                  state_q <= ST_DONE;
                end else begin
                  shift_out_q <= shift_out_q << 1;
                  miso_q      <= shift_out_q[DATA_BITS-2];
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign miso        = miso_q;
  assign cur_ch      = cur_ch_q;
  assign conv_strobe = conv_strobe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_word    = cmd_word_q;
  assign cmd_unsup   = cmd_unsup_q;
  assign frame_err   = frame_err_q;

endmodule
